// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-word bit positions, the canonical NOP and
// the memory-stage handshake states.
package cpu_pkg;

  localparam int CTR_MEMREAD  = 1;
  localparam int CTR_MEMTOREG = 2;
  localparam int CTR_MEMWRITE = 5;
  localparam int CTR_REGWRITE = 7;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Strip every side effect a faulting memory instruction could have in WB.
  function automatic logic [31:0] kill_mem_ctrl(input logic [31:0] ctr);
    logic [31:0] r;
    r               = ctr;
    r[CTR_MEMREAD]  = 1'b0;
    r[CTR_MEMTOREG] = 1'b0;
    r[CTR_MEMWRITE] = 1'b0;
    r[CTR_REGWRITE] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and
// the data memory (slave).
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/dm_handshake_fsm.sv
// Data-memory handshake sequencer: issues the request, waits for load data,
// and holds the captured load word until the MEM/WB write.
module dm_handshake_fsm
  import cpu_pkg::*;
(
  input  logic        clk_cpu,
  input  logic        rst,
  input  logic        i_mem_op,
  input  logic        i_aligned,
  input  logic        i_store,
  input  logic        i_gnt,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  output logic        o_req,
  output logic        o_stall,
  output logic        o_idle,
  output logic        o_done,
  output logic [31:0] o_rbuf
);

  mem_state_e  r_state;
  mem_state_e  w_next;
  logic [31:0] r_rbuf;

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      r_state <= IDLE;
      r_rbuf  <= '0;
    end else begin
      r_state <= w_next;
      // Responses are only meaningful while a load is outstanding.
      if (r_state == WAIT && i_rvalid) begin
        r_rbuf <= i_rdata;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    o_req   = 1'b0;
    o_stall = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_mem_op && i_aligned) begin
          o_req   = 1'b1;
          o_stall = 1'b1;
          if (i_gnt) begin
            w_next = i_store ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        o_stall = 1'b1;
        if (i_rvalid) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Keep the pipeline and the memory quiet while reset is held.
    if (rst) begin
      o_req   = 1'b0;
      o_stall = 1'b0;
    end
  end

  assign o_idle = (r_state == IDLE);
  assign o_done = (r_state == DONE);
  assign o_rbuf = r_rbuf;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: word loads/stores over a variable-latency handshake,
// MEM/WB register with bubble insertion, misalignment flag and stall counter.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk_cpu,
  input  logic                   rst,
  input  logic [31:0]            y,
  input  logic [31:0]            mdw,
  input  logic [31:0]            irm,
  input  logic [31:0]            ctrm,
  mem_stage_if.master            dm,
  output logic                   stall,
  output logic [31:0]            mdr,
  output logic [31:0]            yw,
  output logic [31:0]            irw,
  output logic [31:0]            ctrw,
  output logic                   err_misalign,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic        w_mem_op;
  logic        w_store;
  logic        w_load;
  logic        w_aligned;
  logic        w_misalign;
  logic        w_req;
  logic        w_stall;
  logic        w_idle;
  logic        w_done;
  logic [31:0] w_rbuf;

  logic [31:0]            r_mdr;
  logic [31:0]            r_yw;
  logic [31:0]            r_irw;
  logic [31:0]            r_ctrw;
  logic                   r_err_misalign;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // A control word with both memread and memwrite set is treated as a store.
  assign w_mem_op   = ctrm[CTR_MEMREAD] | ctrm[CTR_MEMWRITE];
  assign w_store    = ctrm[CTR_MEMWRITE];
  assign w_load     = ctrm[CTR_MEMREAD] & ~ctrm[CTR_MEMWRITE];
  assign w_aligned  = (y[1:0] == 2'b00);
  assign w_misalign = w_idle & w_mem_op & ~w_aligned;

  dm_handshake_fsm u_fsm (
    .clk_cpu  (clk_cpu),
    .rst      (rst),
    .i_mem_op (w_mem_op),
    .i_aligned(w_aligned),
    .i_store  (w_store),
    .i_gnt    (dm.dm_gnt),
    .i_rvalid (dm.dm_rvalid),
    .i_rdata  (dm.dm_rdata),
    .o_req    (w_req),
    .o_stall  (w_stall),
    .o_idle   (w_idle),
    .o_done   (w_done),
    .o_rbuf   (w_rbuf)
  );

  assign dm.dm_req   = w_req;
  assign dm.dm_we    = w_store;
  assign dm.dm_addr  = y;
  assign dm.dm_wdata = mdw;

  // MEM/WB register boundary
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      r_mdr  <= '0;
      r_yw   <= '0;
      r_irw  <= NOP_INSN;
      r_ctrw <= '0;
    end else if (w_stall) begin
      r_yw   <= '0;
      r_irw  <= NOP_INSN;
      r_ctrw <= '0;
    end else begin
      r_yw   <= y;
      r_irw  <= irm;
      r_ctrw <= w_misalign ? kill_mem_ctrl(ctrm) : ctrm;
      if (w_done && w_load) begin
        r_mdr <= w_rbuf;
      end
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      r_err_misalign <= 1'b0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_misalign) begin
        r_err_misalign <= 1'b1;
      end
      if (w_stall) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
    end
  end

  assign stall        = w_stall;
  assign mdr          = r_mdr;
  assign yw           = r_yw;
  assign irw          = r_irw;
  assign ctrw         = r_ctrw;
  assign err_misalign = r_err_misalign;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-written
// store, load, misalignment and reset-during-wait sequences.
module tb_mem_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] y, mdw, irm, ctrm;
  logic        stall;
  logic [31:0] mdr, yw, irw, ctrw;
  logic        err_misalign;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_if dm_if ();

  mem_stage #(.STALL_CNT_W(32)) dut (
    .clk_cpu     (clk),
    .rst         (rst),
    .y           (y),
    .mdw         (mdw),
    .irm         (irm),
    .ctrm        (ctrm),
    .dm          (dm_if.master),
    .stall       (stall),
    .mdr         (mdr),
    .yw          (yw),
    .irw         (irw),
    .ctrw        (ctrw),
    .err_misalign(err_misalign),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [31:0] ctrm;
    logic [31:0] irm;
    logic [31:0] mdw;
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] yw;
    logic [31:0] ctrw;
    logic [31:0] irw;
    logic        err;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h5,        32'h80,  32'h00500093, 32'h0,  1'b0, 1'b0, 1'b0, 32'h5,        32'h80,  32'h00500093, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00,  32'h00000033, 32'h1,  1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00,  32'h00000033, 1'b0};
    vecs[2] = '{32'h100,      32'h02,  32'h10002083, 32'h2,  1'b1, 1'b1, 1'b0, 32'h0,        32'h00,  NOP_INSN,     1'b0};
    vecs[3] = '{32'h104,      32'h22,  32'h10402223, 32'h3,  1'b1, 1'b1, 1'b1, 32'h0,        32'h00,  NOP_INSN,     1'b0};
    vecs[4] = '{32'h8,        32'h181, 32'h00800113, 32'h4,  1'b0, 1'b0, 1'b0, 32'h8,        32'h181, 32'h00800113, 1'b0};
    vecs[5] = '{32'h201,      32'h20,  32'h20102023, 32'h5,  1'b0, 1'b0, 1'b0, 32'h201,      32'h00,  32'h20102023, 1'b1};
    vecs[6] = '{32'h3,        32'h04,  32'h00300193, 32'h6,  1'b0, 1'b0, 1'b0, 32'h3,        32'h04,  32'h00300193, 1'b1};

    dm_if.dm_gnt    = 1'b0;
    dm_if.dm_rvalid = 1'b0;
    dm_if.dm_rdata  = 32'h0;
    y    = 32'h20;
    mdw  = 32'h0;
    irm  = 32'h02002083;
    ctrm = 32'h86;
    rst  = 1'b1;

    // Reset with an aligned load presented: outputs must stay quiet.
    tick();
    tick();
    chk("rst_req",   {31'b0, dm_if.dm_req}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_mdr",   mdr, 32'h0);
    chk("rst_yw",    yw, 32'h0);
    chk("rst_ctrw",  ctrw, 32'h0);
    chk("rst_irw",   irw, NOP_INSN);
    chk("rst_err",   {31'b0, err_misalign}, 32'h0);
    chk("rst_cnt",   stall_cnt, 32'h0);

    // Plain ALU instruction.
    rst  = 1'b0;
    y    = 32'h5;
    ctrm = 32'h80;
    irm  = 32'h00500093;
    #1;
    chk("nonmem_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("nonmem_yw",   yw, 32'h5);
    chk("nonmem_ctrw", ctrw, 32'h80);
    chk("nonmem_cnt",  stall_cnt, 32'h0);

    for (int i = 0; i < NV; i++) begin
      y    = vecs[i].y;
      ctrm = vecs[i].ctrm;
      irm  = vecs[i].irm;
      mdw  = vecs[i].mdw;
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].stall});
      chk($sformatf("v%0d_req", i), {31'b0, dm_if.dm_req}, {31'b0, vecs[i].req});
      if (vecs[i].req) begin
        chk($sformatf("v%0d_we", i), {31'b0, dm_if.dm_we}, {31'b0, vecs[i].we});
        chk($sformatf("v%0d_addr", i), dm_if.dm_addr, vecs[i].y);
        chk($sformatf("v%0d_wdata", i), dm_if.dm_wdata, vecs[i].mdw);
      end
      tick();
      chk($sformatf("v%0d_yw", i), yw, vecs[i].yw);
      chk($sformatf("v%0d_ctrw", i), ctrw, vecs[i].ctrw);
      chk($sformatf("v%0d_irw", i), irw, vecs[i].irw);
      chk($sformatf("v%0d_err", i), {31'b0, err_misalign}, {31'b0, vecs[i].err});
    end
    chk("table_cnt", stall_cnt, 32'h2);

    rst  = 1'b1;
    ctrm = 32'h0;
    tick();
    rst = 1'b0;
    chk("rst2_err", {31'b0, err_misalign}, 32'h0);
    chk("rst2_cnt", stall_cnt, 32'h0);

    // Store granted immediately.
    y    = 32'h10;
    mdw  = 32'hAB;
    ctrm = 32'h20;
    irm  = 32'h00B02823;
    dm_if.dm_gnt = 1'b1;
    #1;
    chk("st_req",   {31'b0, dm_if.dm_req}, 32'h1);
    chk("st_we",    {31'b0, dm_if.dm_we}, 32'h1);
    chk("st_addr",  dm_if.dm_addr, 32'h10);
    chk("st_wdata", dm_if.dm_wdata, 32'hAB);
    chk("st_stall", {31'b0, stall}, 32'h1);
    tick();
    dm_if.dm_gnt = 1'b0;
    chk("st_done_stall", {31'b0, stall}, 32'h0);
    chk("st_done_req",   {31'b0, dm_if.dm_req}, 32'h0);
    chk("st_bubble_irw", irw, NOP_INSN);
    chk("st_bubble_ctrw", ctrw, 32'h0);
    tick();
    chk("st_wb_yw",   yw, 32'h10);
    chk("st_wb_ctrw", ctrw, 32'h20);
    chk("st_wb_irw",  irw, 32'h00B02823);
    chk("st_wb_mdr",  mdr, 32'h0);
    chk("st_cnt",     stall_cnt, 32'h1);

    // Back-to-back load: gnt on the 2nd request cycle, rvalid on the 3rd WAIT cycle.
    y    = 32'h20;
    ctrm = 32'h86;
    irm  = 32'h02002083;
    #1;
    chk("ld_reqA",   {31'b0, dm_if.dm_req}, 32'h1);
    chk("ld_weA",    {31'b0, dm_if.dm_we}, 32'h0);
    chk("ld_stallA", {31'b0, stall}, 32'h1);
    tick();
    dm_if.dm_gnt    = 1'b1;
    dm_if.dm_rvalid = 1'b1;
    dm_if.dm_rdata  = 32'h11111111;
    #1;
    chk("ld_reqB", {31'b0, dm_if.dm_req}, 32'h1);
    tick();
    dm_if.dm_gnt    = 1'b0;
    dm_if.dm_rvalid = 1'b0;
    chk("ld_wait_req",   {31'b0, dm_if.dm_req}, 32'h0);
    chk("ld_wait_stall", {31'b0, stall}, 32'h1);
    tick();
    tick();
    dm_if.dm_rvalid = 1'b1;
    dm_if.dm_rdata  = 32'hDEADBEEF;
    #1;
    chk("ld_waitE_stall", {31'b0, stall}, 32'h1);
    tick();
    dm_if.dm_rvalid = 1'b0;
    chk("ld_done_stall", {31'b0, stall}, 32'h0);
    chk("ld_done_irw",   irw, NOP_INSN);
    chk("ld_done_mdr",   mdr, 32'h0);
    tick();
    chk("ld_wb_mdr",  mdr, 32'hDEADBEEF);
    chk("ld_wb_ctrw", ctrw, 32'h86);
    chk("ld_wb_yw",   yw, 32'h20);
    chk("ld_wb_irw",  irw, 32'h02002083);
    chk("ld_cnt",     stall_cnt, 32'h6);

    // Misaligned access: no request, no stall, side effects stripped.
    y    = 32'h22;
    ctrm = 32'hFF;
    irm  = 32'h02202083;
    #1;
    chk("mis_req",   {31'b0, dm_if.dm_req}, 32'h0);
    chk("mis_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("mis_err",  {31'b0, err_misalign}, 32'h1);
    chk("mis_ctrw", ctrw, 32'h59);
    chk("mis_yw",   yw, 32'h22);
    chk("mis_irw",  irw, 32'h02202083);
    chk("mis_mdr",  mdr, 32'hDEADBEEF);
    y    = 32'h9;
    ctrm = 32'h80;
    tick();
    chk("mis_sticky", {31'b0, err_misalign}, 32'h1);
    chk("mis_cnt",    stall_cnt, 32'h6);

    // Reset while waiting for load data, then a late response.
    y    = 32'h40;
    ctrm = 32'h02;
    irm  = 32'h04002083;
    dm_if.dm_gnt = 1'b1;
    tick();
    dm_if.dm_gnt = 1'b0;
    chk("rw_wait_stall", {31'b0, stall}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rw_rst_stall", {31'b0, stall}, 32'h0);
    chk("rw_rst_req",   {31'b0, dm_if.dm_req}, 32'h0);
    chk("rw_rst_mdr",   mdr, 32'h0);
    chk("rw_rst_irw",   irw, NOP_INSN);
    rst  = 1'b0;
    y    = 32'h7;
    ctrm = 32'h80;
    irm  = 32'h00700093;
    dm_if.dm_rvalid = 1'b1;
    dm_if.dm_rdata  = 32'h55555555;
    #1;
    chk("rw_late_stall", {31'b0, stall}, 32'h0);
    tick();
    dm_if.dm_rvalid = 1'b0;
    #1;
    chk("rw_late_stall2", {31'b0, stall}, 32'h0);
    chk("rw_late_mdr", mdr, 32'h0);
    chk("rw_late_irw", irw, 32'h00700093);
    chk("rw_late_yw",  yw, 32'h7);
    chk("rw_cnt",      stall_cnt, 32'h0);
    tick();
    chk("rw_after_mdr", mdr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
